jk_ff_loop_checker: RTL

- Far end of the flip-flop conversion experiment: drives J/K stimulus and a slow clock to an external converted flip-flop on the Vaman breadboard, then reads its Q back.
- Compares each readback against the JK characteristic equation, counts mismatches and drives pass/fail LEDs.
- Runs from the 20 MHz Sys_Clk0-derived clk; its slow clock is the same divided-tick scheme the converter demo uses.

---
 rtl/ff_lab_pkg.sv | 16 +
 rtl/jk_ff_loop_checker_if.sv | 13 +
 rtl/slow_tick_gen.sv | 35 +++
 rtl/jk_ff_loop_checker.sv | 101 ++++++++++
 4 files changed

// File: rtl/ff_lab_pkg.sv
// Shared definitions for the flip-flop conversion lab: FSM states, the JK
// stimulus sequence and the Q values it must produce.
package ff_lab_pkg;
  localparam int DIV_W  = 27;
  localparam int NSTEPS = 8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // {J,K} per step; step 0 sets Q so the power-up state never matters
  localparam logic [1:0] STIM_JK [NSTEPS] = '{
    2'b10, 2'b00, 2'b01, 2'b00, 2'b11, 2'b11, 2'b10, 2'b11
  };
  localparam logic EXP_Q [NSTEPS] = '{
    1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0
  };
endpackage

// File: rtl/jk_ff_loop_checker_if.sv
// Breadboard link to the external flip-flop plus the status LEDs/counter.
interface jk_ff_loop_checker_if #(parameter int ERR_W = 4);
  logic             q_in;
  logic             clock1;
  logic             j_out;
  logic             k_out;
  logic             led_pass;
  logic             led_fail;
  logic [ERR_W-1:0] err_cnt;

  modport master (input q_in, output clock1, j_out, k_out, led_pass, led_fail, err_cnt);
  modport slave  (output q_in, input clock1, j_out, k_out, led_pass, led_fail, err_cnt);
endinterface

// File: rtl/slow_tick_gen.sv
// Divided tick and slow clock shared by the converter demo blocks.
// clock1 only runs while en is high and parks low otherwise.
module slow_tick_gen
  import ff_lab_pkg::*;
#(
  parameter int DIV_COUNT = 20000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick,
  output logic rise,
  output logic fall,
  output logic clock1
);
  localparam logic [DIV_W-1:0] TOP = DIV_W'(DIV_COUNT - 1);

  logic [DIV_W-1:0] cnt;

  assign tick = (cnt == TOP);
  // strobes mark the tick on which clock1 is about to change
  assign rise = tick & en & ~clock1;
  assign fall = tick & en & clock1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      clock1 <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (!en)       clock1 <= 1'b0;
      else if (tick) clock1 <= ~clock1;
    end
  end
endmodule

// File: rtl/jk_ff_loop_checker.sv
// Drives J/K and a slow clock to an external converted flip-flop, checks its
// Q against the JK characteristic half a slow period after each rising edge.
module jk_ff_loop_checker
  import ff_lab_pkg::*;
#(
  parameter int DIV_COUNT = 20000000,
  parameter int LOOP      = 0,
  parameter int ERR_W     = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  jk_ff_loop_checker_if.master  bus
);
  state_t           state, state_nxt;
  logic [2:0]       step, step_nxt;
  logic             j, j_nxt, k, k_nxt;
  logic [ERR_W-1:0] err, err_nxt;
  logic             pass, pass_nxt, fail, fail_nxt;
  logic [1:0]       sync;
  logic             q_s;
  logic             tick, rise, fall, clock1;

  slow_tick_gen #(.DIV_COUNT(DIV_COUNT)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state == RUN),
    .tick   (tick),
    .rise   (rise),
    .fall   (fall),
    .clock1 (clock1)
  );

  assign q_s = sync[1];

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    j_nxt     = j;
    k_nxt     = k;
    err_nxt   = err;
    case (state)
      IDLE: if (tick) begin
        {j_nxt, k_nxt} = STIM_JK[0];
        state_nxt      = RUN;
      end
      RUN: if (fall) begin
        if (q_s != EXP_Q[step] && err != '1) err_nxt = err + 1'b1;
        if (step == 3'd7) begin
          {j_nxt, k_nxt} = 2'b00;
          state_nxt      = DONE;
        end else begin
          // new J/K lands half a period ahead of the next rising edge
          step_nxt       = step + 3'd1;
          {j_nxt, k_nxt} = STIM_JK[step + 3'd1];
        end
      end
      DONE: begin
        {j_nxt, k_nxt} = 2'b00;
        if (LOOP != 0 && tick) begin
          step_nxt       = 3'd0;
          {j_nxt, k_nxt} = STIM_JK[0];
          state_nxt      = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
    pass_nxt = (state_nxt == DONE) && (err_nxt == '0);
    fail_nxt = fail | (err != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      step  <= '0;
      j     <= 1'b0;
      k     <= 1'b0;
      err   <= '0;
      pass  <= 1'b0;
      fail  <= 1'b0;
      sync  <= '0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
      j     <= j_nxt;
      k     <= k_nxt;
      err   <= err_nxt;
      pass  <= pass_nxt;
      fail  <= fail_nxt;
      sync  <= {sync[0], bus.q_in};
    end
  end

  assign bus.clock1   = clock1;
  assign bus.j_out    = j;
  assign bus.k_out    = k;
  assign bus.err_cnt  = err;
  assign bus.led_pass = pass;
  assign bus.led_fail = fail;

  a_strobes_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(rise && fall));
endmodule
